// File: rtl/vga_sync_gen_if.sv
// Scan interface: pixel enable, coordinates and sync qualifiers from the
// timing generator to the renderer and the connector.
interface vga_sync_gen_if;
   logic       p_tick;
   logic [9:0] x;
   logic [9:0] y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       frame_tick;

   modport master (
      output p_tick, x, y, video_on, hsync, vsync, frame_tick
   );

   modport slave (
      input p_tick, x, y, video_on, hsync, vsync, frame_tick
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, x/y scan counters and registered
// sync/blanking qualifiers aligned with the counters they describe.
module vga_sync_gen #(
   parameter int unsigned PIX_DIV   = 4,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic           clk,
   input  logic           reset,
   vga_sync_gen_if.master scan
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);
   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             p_tick;
   logic [9:0]       x_q, y_q;
   logic [9:0]       x_nxt, y_nxt;
   logic             hsync_q, vsync_q, video_on_q, frame_tick_q;

   // With PIX_DIV == 1 the divider is stuck at 0 == DIV_MAX, so p_tick is constant 1.
   assign p_tick = (div_cnt == DIV_MAX);

   always_comb begin
      x_nxt = x_q;
      y_nxt = y_q;
      if (p_tick) begin
         if (x_q == H_MAX) begin
            x_nxt = '0;
            y_nxt = (y_q == V_MAX) ? '0 : y_q + 10'd1;
         end else begin
            x_nxt = x_q + 10'd1;
         end
      end
   end

   // Qualifiers are computed from the next-state counters so they change on
   // the same edge as x/y instead of one pixel later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt      <= '0;
         x_q          <= '0;
         y_q          <= '0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         video_on_q   <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         div_cnt      <= p_tick ? '0 : div_cnt + 1'b1;
         x_q          <= x_nxt;
         y_q          <= y_nxt;
         hsync_q      <= !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
         vsync_q      <= !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
         video_on_q   <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
         frame_tick_q <= p_tick && (x_q == H_MAX) && (y_q == V_MAX);
      end
   end

   assign scan.p_tick     = p_tick;
   assign scan.x          = x_q;
   assign scan.y          = y_q;
   assign scan.video_on   = video_on_q;
   assign scan.hsync      = hsync_q;
   assign scan.vsync      = vsync_q;
   assign scan.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a PIX_DIV=4 instance with full line timing
// and a short frame, plus a PIX_DIV=1 instance with tiny timing.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   vga_sync_gen_if sa ();
   vga_sync_gen_if sb ();

   // A: 800-pixel lines, 8-line frames (visible 4, vsync on line 6).
   vga_sync_gen #(
      .PIX_DIV(4), .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(1), .V_BACK(1)
   ) dut_a (
      .clk(clk), .reset(reset), .scan(sa)
   );

   // B: one pixel per clk, 16-pixel lines (hsync 10..12), 8-line frames (vsync on 5).
   vga_sync_gen #(
      .PIX_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2)
   ) dut_b (
      .clk(clk), .reset(reset), .scan(sb)
   );

   int total = 0;
   int bad   = 0;
   int n     = 0;   // active edges since reset release

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected values from elapsed edges: pixel index = n / PIX_DIV.
   task automatic check_a();
      int p, ex, ey;
      p  = n / 4;
      ex = p % 800;
      ey = (p / 800) % 8;
      chk("a_x", 32'(sa.x), 32'(ex));
      chk("a_y", 32'(sa.y), 32'(ey));
      chk("a_p_tick", 32'(sa.p_tick), 32'((n % 4) == 3));
      chk("a_hsync", 32'(sa.hsync), 32'(!(ex >= 656 && ex <= 751)));
      chk("a_vsync", 32'(sa.vsync), 32'(ey != 6));
      chk("a_video_on", 32'(sa.video_on), 32'(ex < 640 && ey < 4));
      chk("a_frame_tick", 32'(sa.frame_tick), 32'(n >= 25600 && (n % 25600) == 0));
   endtask

   task automatic check_b();
      int ex, ey;
      ex = n % 16;
      ey = (n / 16) % 8;
      chk("b_x", 32'(sb.x), 32'(ex));
      chk("b_y", 32'(sb.y), 32'(ey));
      chk("b_p_tick", 32'(sb.p_tick), 32'd1);
      chk("b_hsync", 32'(sb.hsync), 32'(!(ex >= 10 && ex <= 12)));
      chk("b_vsync", 32'(sb.vsync), 32'(ey != 5));
      chk("b_video_on", 32'(sb.video_on), 32'(ex < 8 && ey < 4));
      chk("b_frame_tick", 32'(sb.frame_tick), 32'(n >= 128 && (n % 128) == 0));
   endtask

   int a_pt_cnt = 0, b_pt_cnt = 0, hs_low_cnt = 0, vs_low_cnt = 0;
   int a_ft_cnt = 0, b_ft_cnt = 0, a_ft_last = -1, a_ft_gap = 0;
   int refresh_hits = 0, max_x = 0, max_y = 0;
   int hs_first_x = -1, vo_fall_x = -1, post_rst_ft = 0;
   logic [9:0] prev_x, prev_y;
   logic       prev_refresh = 1'b0;

   task automatic step();
      prev_x = sa.x;
      prev_y = sa.y;
      @(negedge clk);
      n++;
      check_a();
      check_b();
   endtask

   initial begin
      // Reset held for 10 clks.
      repeat (10) @(negedge clk);
      n = 0;
      chk("rst_a_x", 32'(sa.x), 32'd0);
      chk("rst_a_y", 32'(sa.y), 32'd0);
      chk("rst_a_hsync", 32'(sa.hsync), 32'd1);
      chk("rst_a_vsync", 32'(sa.vsync), 32'd1);
      chk("rst_a_video_on", 32'(sa.video_on), 32'd1);
      chk("rst_a_frame_tick", 32'(sa.frame_tick), 32'd0);
      chk("rst_a_p_tick", 32'(sa.p_tick), 32'd0);
      chk("rst_b_p_tick", 32'(sb.p_tick), 32'd1);
      reset = 1'b1;

      // Two full frames of A (and 400 of B), every cycle checked.
      for (int i = 0; i < 51200; i++) begin
         step();
         if (n == 3) chk("first_p_tick_edge3", 32'(sa.p_tick), 32'd1);
         if (n == 4) chk("x1_after_edge4", 32'(sa.x), 32'd1);
         if (n == 3200) begin
            chk("wrap_prev_x", 32'(prev_x), 32'd799);
            chk("wrap_prev_y", 32'(prev_y), 32'd0);
            chk("wrap_x", 32'(sa.x), 32'd0);
            chk("wrap_y", 32'(sa.y), 32'd1);
         end
         if (n <= 40) begin
            a_pt_cnt += int'(sa.p_tick);
            b_pt_cnt += int'(sb.p_tick);
         end
         if (n < 3200 && !sa.hsync) begin
            hs_low_cnt++;
            if (hs_first_x < 0) hs_first_x = int'(sa.x);
         end
         if (n < 3200 && !sa.video_on && vo_fall_x < 0) vo_fall_x = int'(sa.x);
         if (!sa.vsync) vs_low_cnt++;
         if (sa.frame_tick) begin
            if (a_ft_last >= 0) a_ft_gap = n - a_ft_last;
            a_ft_last = n;
            a_ft_cnt++;
         end
         b_ft_cnt += int'(sb.frame_tick);
         if (sa.x == 10'd0 && sa.y == 10'd5 && !prev_refresh) begin
            refresh_hits++;
            chk("refresh_video_on", 32'(sa.video_on), 32'd0);
         end
         prev_refresh = (sa.x == 10'd0 && sa.y == 10'd5);
         if (int'(sa.x) > max_x) max_x = int'(sa.x);
         if (int'(sa.y) > max_y) max_y = int'(sa.y);
      end

      chk("p_tick_count_div4", 32'(a_pt_cnt), 32'd10);
      chk("p_tick_count_div1", 32'(b_pt_cnt), 32'd40);
      chk("hsync_low_clks", 32'(hs_low_cnt), 32'd384);
      chk("hsync_first_x", 32'(hs_first_x), 32'd656);
      chk("video_on_fall_x", 32'(vo_fall_x), 32'd640);
      chk("vsync_low_clks", 32'(vs_low_cnt), 32'd6400);
      chk("frame_tick_count_a", 32'(a_ft_cnt), 32'd2);
      chk("frame_tick_gap_a", 32'(a_ft_gap), 32'd25600);
      chk("frame_tick_count_b", 32'(b_ft_cnt), 32'd400);
      chk("refresh_point_hits", 32'(refresh_hits), 32'd2);
      chk("max_x", 32'(max_x), 32'd799);
      chk("max_y", 32'(max_y), 32'd7);

      // Advance A to (300, 2) in the third frame, then reset between edges.
      for (int i = 0; i < 7600; i++) step();
      chk("pre_rst_x", 32'(sa.x), 32'd300);
      chk("pre_rst_y", 32'(sa.y), 32'd2);
      #1 reset = 1'b0;
      #1;
      n = 0;
      check_a();
      check_b();
      @(negedge clk);
      check_a();
      reset = 1'b1;

      for (int i = 0; i < 300; i++) begin
         step();
         post_rst_ft += int'(sa.frame_tick);
      end
      chk("no_frame_tick_after_reset", 32'(post_rst_ft), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing from the 100 MHz system clock and drives the `x`, `y` and `video_on` scan coordinates consumed by the `pixel` renderer, plus `hsync` and `vsync` for the connector. It is the producing end of the scan interface. All game logic keys off these counters, including the renderer's refresh point at y == 481, x == 0.

## Interface
Parameters:
- `PIX_DIV`, 4: system clocks per pixel. Must be ≥ 1.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels. H_TOTAL = 800.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines. V_TOTAL = 525.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-low reset. Asserting it low clears all state immediately.
- `p_tick` out 1: pixel enable. High for 1 clk every PIX_DIV clks.
- `x` out 10: horizontal count, 0..H_TOTAL-1.
- `y` out 10: vertical count, 0..V_TOTAL-1.
- `video_on` out 1: high when x < H_DISPLAY and y < V_DISPLAY.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `frame_tick` out 1: 1-clk pulse at the start of each frame.

## Operation
- Divider `div_cnt` (width clog2(PIX_DIV), minimum 1 bit):
  - counts 0..PIX_DIV-1, then wraps to 0;
  - `p_tick` = (div_cnt == PIX_DIV-1), combinational from the register;
  - if PIX_DIV == 1, `p_tick` is constantly 1 out of reset.
- Counters change only on a clk edge where `p_tick` == 1:
  - x < H_TOTAL-1: x increments.
  - x == H_TOTAL-1: x wraps to 0; y increments, or wraps to 0 if y == V_TOTAL-1.
- Sync windows:
  - `hsync` is low for H_DISPLAY+H_FRONT ≤ x ≤ H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751 with defaults.
  - `vsync` is low for V_DISPLAY+V_FRONT ≤ y ≤ V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491 with defaults.
- `x`, `y`, `hsync`, `vsync`, `video_on` and `frame_tick` are all registers.
  - `hsync`, `vsync` and `video_on` are computed from the next-state counter values, so at every cycle they match the current `x`/`y` exactly. There is no pipeline skew between coordinates and qualifiers.
- `frame_tick` is high for exactly one clk: the cycle immediately after the edge on which (x,y) changes from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is never asserted by reset.
- Width rules:
  - all arithmetic is unsigned 10-bit;
  - H_TOTAL and V_TOTAL must each be ≤ 1024;
  - counters never exceed TOTAL-1, and no value outside range is ever driven.
- Reset values, applied asynchronously while `reset` is low:
  - div_cnt = 0, x = 0, y = 0;
  - hsync = 1, vsync = 1, video_on = 1;
  - frame_tick = 0;
  - p_tick = 0, or 1 if PIX_DIV == 1.
- Reset release: the first `p_tick` occurs PIX_DIV clks after the first active edge. The frame starting at (0,0) out of reset does not produce `frame_tick`.

## Timing
- Pixel period: PIX_DIV clks (40 ns with defaults).
- Line period: H_TOTAL × PIX_DIV = 3200 clks.
- Frame period: H_TOTAL × V_TOTAL × PIX_DIV = 1,680,000 clks.
- Output latency:
  - `x`/`y` are valid on the same edge that consumes `p_tick`;
  - the qualifiers (`hsync`, `vsync`, `video_on`) change on that same edge, with zero cycles relative to `x`/`y`.
- Line and frame wrap: the x wrap and y increment happen on the same edge, never on split cycles. At the (799,524) → (0,0) edge, both counters wrap together.
- `hsync` and `vsync` edges are glitch-free because they are register outputs.
- Reset mid-frame: all outputs take their reset values without waiting for a clk edge. Counting restarts from (0,0) after release.
- The point (x = 0, y = 481) is reached once per frame and lasts PIX_DIV clks. The renderer depends on this point being in the front porch with `video_on` = 0.

## Test plan
- Reset: hold `reset` = 0 for 10 clks. Required: x = 0, y = 0, hsync = 1, vsync = 1, video_on = 1, frame_tick = 0, p_tick = 0. Release; p_tick first goes high on clk 4 and x = 1 after clk 4's edge.
- Divider: run 40 clks with PIX_DIV = 4. Required: exactly 10 p_tick pulses, each 1 clk wide, spaced 4 clks apart. Repeat with PIX_DIV = 1: p_tick is constant 1 and x increments every clk.
- Line: run one full line. Required:
  - hsync low for exactly 96 pixels (384 clks), starting at x = 656;
  - video_on falls at x = 640;
  - x goes 799 → 0 with y 0 → 1 on the same edge.
- Frame: run two frames. Required:
  - vsync low only for y = 490..491 (1600 pixels);
  - video_on = 0 for all y ≥ 480;
  - exactly one frame_tick per frame, 1,680,000 clks apart;
  - (x = 0, y = 481) observed once per frame.
- Async reset: assert `reset` low between clk edges at x = 300, y = 200. Required: outputs reach reset values before the next edge. After release, counting resumes from (0,0) and no frame_tick is produced by the reset.
- Boundaries: sample every pixel of one frame. Required: x ≤ 799 and y ≤ 524 always; video_on == (x < 640 && y < 480) on every cycle.
